// File: rtl/multi_edge_detect.sv
// multi_edge_detect
//   Per-channel synchroniser, glitch filter and edge detector with sticky
//   event flags and a saturating aggregate event counter.
//
// Parameters
//   WIDTH          number of independent channels (1..32)
//   SYNC_STAGES    synchroniser depth per channel (2..4)
//   FILTER_CYCLES  cycles a changed input must hold before acceptance (1..255)
//   CNT_WIDTH      width of edge_count
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in          raw asynchronous channel inputs
//   mode        shared event select: 00 none, 01 rise, 10 fall, 11 both
//   ack         write-one-to-clear for pending
//   clear       synchronous clear of edge_count (same-cycle events still count)
//   out         one-cycle event pulse per channel (registered)
//   level       filtered, synchronised channel level (registered)
//   pending     sticky per-channel event flags
//   irq         OR of pending
//   edge_count  saturating count of all events
//
// Handshake: there is no valid/ready flow control. out is a pure one-cycle
// strobe; pending holds each event until software acks it, and a new event
// in the ack cycle wins over the ack.
module multi_edge_detect #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     ack,
  input  logic                 clear,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     level,
  output logic [WIDTH-1:0]     pending,
  output logic                 irq,
  output logic [CNT_WIDTH-1:0] edge_count
);

  localparam int FCW = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam int PCW = $clog2(WIDTH + 1);
  // Sum width wide enough that count + popcount can never wrap before the
  // saturation compare.
  localparam int SW  = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;

  localparam logic [FCW-1:0]       FC_LAST = FCW'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     s;
  logic [FCW-1:0]       cnt_q  [WIDTH];
  logic [FCW-1:0]       cnt_d  [WIDTH];
  logic [WIDTH-1:0]     level_q, level_d;
  logic [WIDTH-1:0]     rise, fall;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     pending_q, pending_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [PCW-1:0]       pop;
  logic [SW-1:0]        base, sum;

  assign s = sync_q[SYNC_STAGES-1];

  // Filter: a channel's counter advances only while the synchronised input
  // disagrees with the accepted level; any agreement restarts the window,
  // so short excursions never reach acceptance.
  always_comb begin
    level_d = level_q;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == FC_LAST) begin
          level_d[i] = s[i];
          rise[i]    = s[i];
          fall[i]    = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + FCW'(1);
        end
      end
    end
  end

  // Level tracking is unconditional; mode only gates the reported events.
  assign out_d = (rise & {WIDTH{mode[0]}}) | (fall & {WIDTH{mode[1]}});

  // pending and edge_count react to the cycle in which out is high, so they
  // update one edge after the pulse appears.
  assign pending_d = out_q | (pending_q & ~ack);

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PCW'(out_q[i]);
    end
  end

  always_comb begin
    base    = clear ? '0 : SW'(count_q);
    sum     = base + SW'(pop);
    count_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q   <= '0;
      out_q     <= '0;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q   <= level_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign out        = out_q;
  assign level      = level_q;
  assign pending    = pending_q;
  assign irq        = |pending_q;
  assign edge_count = count_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect (WIDTH=4, SYNC_STAGES=2, FILTER_CYCLES=3,
// CNT_WIDTH=4). Expected out pulses are queued as {edge index, mask} when
// the input change is driven and popped by a negedge monitor.
module tb_multi_edge_detect;

  localparam int W  = 4;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  in;
  logic [1:0]    mode;
  logic [W-1:0]  ack;
  logic          clear;
  logic [W-1:0]  out;
  logic [W-1:0]  level;
  logic [W-1:0]  pending;
  logic          irq;
  logic [CW-1:0] edge_count;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  multi_edge_detect #(
    .WIDTH(W), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .mode(mode), .ack(ack),
    .clear(clear), .out(out), .level(level), .pending(pending),
    .irq(irq), .edge_count(edge_count)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_evt(input int unsigned at, input logic [W-1:0] m);
    logic [15:0] a;
    a = at[15:0];
    exp_q.push_back({a, m});
  endtask

  always @(negedge clk) begin
    if (out !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {28'b0, out}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_event", {12'b0, cyc[15:0], out}, {12'b0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"},     {28'b0, out}, 32'h0);
    check({tag, "_level"},   {28'b0, level}, 32'h0);
    check({tag, "_pending"}, {28'b0, pending}, 32'h0);
    check({tag, "_irq"},     {31'b0, irq}, 32'h0);
    check({tag, "_count"},   {28'b0, edge_count}, 32'h0);
  endtask

  int exp_cnt;

  initial begin
    reset = 1'b0;
    in    = '0;
    mode  = 2'b00;
    ack   = '0;
    clear = 1'b0;
    #1;
    check_all_zero("reset");
    tick(2);
    reset = 1'b1;
    tick(3);

    // Single rise on channel 0, rising mode
    mode = 2'b01;
    in   = 4'b0001;
    push_evt(cyc + 5, 4'b0001);
    tick(5);
    check("t1_level", {28'b0, level}, 32'h1);
    tick(1);
    check("t1_pending", {28'b0, pending}, 32'h1);
    check("t1_irq", {31'b0, irq}, 32'h1);
    check("t1_count", {28'b0, edge_count}, 32'd1);
    ack = 4'b0001;
    tick(1);
    ack = '0;
    check("t1_ack_pending", {28'b0, pending}, 32'h0);
    check("t1_ack_irq", {31'b0, irq}, 32'h0);

    // Glitch filtering on channel 2, both edges
    mode  = 2'b11;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t2_clear", {28'b0, edge_count}, 32'd0);
    in[2] = 1'b1;
    tick(2);
    in[2] = 1'b0;
    tick(8);
    check("t2_glitch_level", {28'b0, level}, 32'h1);
    check("t2_glitch_count", {28'b0, edge_count}, 32'd0);
    in[2] = 1'b1;
    push_evt(cyc + 5, 4'b0100);
    tick(3);
    in[2] = 1'b0;
    push_evt(cyc + 5, 4'b0100);
    tick(7);
    check("t2_level", {28'b0, level}, 32'h1);
    check("t2_count", {28'b0, edge_count}, 32'd2);
    check("t2_pending", {28'b0, pending}, 32'h4);

    // Falling-only mode on channel 1, ack colliding with a new event
    ack = 4'hF;
    tick(1);
    ack  = '0;
    mode = 2'b10;
    in[1] = 1'b1;
    tick(6);
    check("t3_rise_level", {28'b0, level}, 32'h3);
    check("t3_rise_pending", {28'b0, pending}, 32'h0);
    check("t3_rise_count", {28'b0, edge_count}, 32'd2);
    in[1] = 1'b0;
    push_evt(cyc + 5, 4'b0010);
    tick(5);
    ack = 4'b0010;
    tick(1);
    ack = '0;
    check("t3_set_wins", {28'b0, pending}, 32'h2);
    check("t3_count", {28'b0, edge_count}, 32'd3);
    ack = 4'b0010;
    tick(1);
    ack = '0;
    check("t3_ack", {28'b0, pending}, 32'h0);

    // All channels toggling together: counter saturation, clear with events
    mode  = 2'b11;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in = ~in;
      push_evt(cyc + 5, 4'hF);
      tick(6);
      exp_cnt = (4 * k > 15) ? 15 : 4 * k;
      check("t4_sat_count", {28'b0, edge_count}, exp_cnt);
    end
    in = ~in;
    push_evt(cyc + 5, 4'hF);
    tick(5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t4_clear_with_events", {28'b0, edge_count}, 32'd4);

    // Reset in the middle of a filter window
    mode = 2'b01;
    tick(2);
    in = 4'b1001;
    tick(2);
    reset = 1'b0;
    #1;
    check_all_zero("t5_reset");
    tick(2);
    reset = 1'b1;
    push_evt(cyc + 5, 4'b1001);
    tick(4);
    check("t5_no_early", {28'b0, level}, 32'h0);
    tick(1);
    check("t5_level", {28'b0, level}, 32'h9);
    tick(1);
    check("t5_pending", {28'b0, pending}, 32'h9);
    check("t5_count", {28'b0, edge_count}, 32'd2);
    check("t5_irq", {31'b0, irq}, 32'h1);

    tick(3);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_edge_detect.md
MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per channel (2..4).
REQ-003 SHALL have parameter FILTER_CYCLES, default 3: consecutive cycles a changed input must hold before acceptance (1..255).
REQ-004 SHALL have parameter CNT_WIDTH, default 8: width of the aggregate event counter.
REQ-005 SHALL have the following ports:
  - clk  input  1  single clock; all state updates on rising edge.
  - reset  input  1  asynchronous, active-low reset.
  - in  input  WIDTH  asynchronous raw channel inputs.
  - mode  input  2  event select, shared by all channels: 00 none, 01 rising, 10 falling, 11 both.
  - ack  input  WIDTH  write-one-to-clear for pending bits.
  - clear  input  1  synchronous clear of edge_count.
  - out  output  WIDTH  one-cycle event pulse per channel, registered.
  - level  output  WIDTH  filtered, synchronised channel level, registered.
  - pending  output  WIDTH  sticky per-channel event flags.
  - irq  output  1  OR of pending.
  - edge_count  output  CNT_WIDTH  saturating count of all events.

Function
REQ-006 SHALL pass each in[i] through a SYNC_STAGES-deep flop chain; s[i] denotes the last stage.
REQ-007 SHALL keep a per-channel filter counter of ceil(log2(FILTER_CYCLES+1)) bits: cleared whenever s[i]==level[i], incremented whenever s[i]!=level[i].
REQ-008 SHALL, on the edge where s[i]!=level[i] and the counter equals FILTER_CYCLES-1, set level[i]<=s[i] and counter<=0; a rise is 0->1 and a fall is 1->0.
REQ-009 SHALL drop any input excursion lasting fewer than FILTER_CYCLES cycles at s[i]: level unchanged, no event.
REQ-010 SHALL assert out[i] on the same edge that level[i] updates, for exactly one cycle, only when mode selects that edge type; otherwise out[i]=0.
REQ-011 SHALL give a latency of SYNC_STAGES+FILTER_CYCLES edges from the first edge sampling a new stable in[i] to out[i]/level[i] updating (5 with defaults).
REQ-012 SHALL track level regardless of mode; mode=00 suppresses out, pending and counting only. A mode change applies to the next edge's evaluation.
REQ-013 SHALL set pending[i] on any cycle with out[i]=1 and clear it on a cycle with ack[i]=1; set wins when both occur in the same cycle.
REQ-014 SHALL drive irq combinationally as |pending.
REQ-015 SHALL add popcount(out) for each cycle to edge_count, saturating at 2^CNT_WIDTH-1 with no wrap.
REQ-016 SHALL, when clear=1, load edge_count with that cycle's popcount(out); events in the clear cycle are counted, not lost.
REQ-017 SHALL process channels independently; simultaneous events on all WIDTH channels SHALL all be reported in one cycle.

Reset
REQ-018 SHALL, while reset=0, immediately force synchroniser flops, filter counters, level, out, pending and edge_count to 0, and irq to 0.
REQ-019 SHALL resume on the first rising edge after reset deasserts; an input held high through reset produces a rise event after the REQ-011 latency, if mode allows.
REQ-020 SHALL discard any filter progress or pending event when reset asserts mid-operation.

Verification
REQ-021 Defaults, mode=01, in[0] 0->1 held: out[0]=1 for exactly one cycle on the 5th edge; level[0]=1; pending[0]=1; irq=1; edge_count=1.
REQ-022 Defaults, mode=11, in[2] glitch high for 2 cycles then low: no out, level[2] stays 0; a glitch of 3 cycles produces rise then fall pulses; edge_count=2.
REQ-023 Mode=10, rise on in[1]: level[1]=1, no out; subsequent fall: out[1] pulse; pending[1] set; ack[1] in the same cycle as a new pulse leaves pending[1]=1.
REQ-024 CNT_WIDTH=4, 4 channels toggling together in mode=11 repeatedly: edge_count 4,8,12,15,15; clear with 4 events in the same cycle gives edge_count=4.
REQ-025 Reset pulled low 2 cycles into a filter window with in[3]=1: all outputs 0 immediately; after release, with in[3] still 1, rise event after full 5-edge latency.
